// File: rtl/isp_pkg.sv
// Shared definitions for the ISP statistics blocks.
//   ACC_W       : accumulator / result width
//   DRAIN_CYC   : cycles spent draining the pixel pipeline after frame end
//   awb_state_e : frame FSM state encoding
package isp_pkg;

    localparam int ACC_W     = 32;
    localparam int DRAIN_CYC = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } awb_state_e;

endpackage

// File: rtl/sat_acc32.sv
// Saturating 32-bit accumulator: adds 'add' when 'en' is high, sticks at
// all-ones instead of wrapping.
//   pclk, rst : clock, synchronous active-high reset
//   clr       : clear to zero (wins over en)
//   en, add   : accumulate enable and addend
//   acc       : accumulated value
module sat_acc32
    import isp_pkg::*;
(
    input  logic             pclk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [ACC_W-1:0] add,
    output logic [ACC_W-1:0] acc
);

    logic [ACC_W:0] sum;

    assign sum = {1'b0, acc} + {1'b0, add};

    always_ff @(posedge pclk) begin
        if (rst || clr)
            acc <= '0;
        else if (en)
            acc <= sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    end

endmodule

// File: rtl/isp_stat_awb.sv
// Auto-white-balance frame statistics: counts qualifying pixels and sums
// their R/G/B components over one in_vsync frame, then publishes the
// result with a one-cycle stat_done pulse.
//   pclk, rst            : pixel clock, synchronous active-high reset
//   in_vsync, in_href    : frame / pixel-valid strobes
//   in_r, in_g, in_b     : pixel components (BITS wide)
//   win_x0/x1/y0/y1      : inclusive statistics window (only with
//                          ISP_STAT_AWB_WINDOW_EN defined)
//   stat_done            : result valid pulse
//   pix_cnt, sum_r/g/b   : frame results, held between pulses
// Build option: define ISP_STAT_AWB_WINDOW_EN to restrict statistics to a
// rectangular window; otherwise the whole frame is eligible.
module isp_stat_awb
    import isp_pkg::*;
#(
    parameter int BITS    = 8,
    parameter int SAT_TH  = 2**BITS - 6,
    parameter int DARK_TH = 4
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             in_vsync,
    input  logic             in_href,
    input  logic [BITS-1:0]  in_r,
    input  logic [BITS-1:0]  in_g,
    input  logic [BITS-1:0]  in_b,
`ifdef ISP_STAT_AWB_WINDOW_EN
    input  logic [11:0]      win_x0,
    input  logic [11:0]      win_x1,
    input  logic [11:0]      win_y0,
    input  logic [11:0]      win_y1,
`endif
    output logic             stat_done,
    output logic [ACC_W-1:0] pix_cnt,
    output logic [ACC_W-1:0] sum_r,
    output logic [ACC_W-1:0] sum_g,
    output logic [ACC_W-1:0] sum_b
);

    localparam logic [ACC_W-1:0] SAT_V  = ACC_W'(SAT_TH);
    localparam logic [ACC_W-1:0] DARK_V = ACC_W'(DARK_TH);

    awb_state_e       state_q, state_d;
    logic [1:0]       drain_q;
    logic             vsync_d;
    logic             vs_rise;
    logic             start;

    logic [ACC_W-1:0] ext_r, ext_g, ext_b;
    logic             in_range;
    logic             win_ok;
    logic             qual;

    logic             s1_vld;
    logic [ACC_W-1:0] s1_r, s1_g, s1_b;
    logic [ACC_W-1:0] acc_cnt, acc_r, acc_g, acc_b;

    assign vs_rise = in_vsync & ~vsync_d;

    // ---------------- frame FSM ----------------
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            drain_q <= '0;
            // Preset high so a reset taken while in_vsync is already high
            // does not see a false rising edge and count a partial frame.
            vsync_d <= 1'b1;
        end else begin
            state_q <= state_d;
            drain_q <= (state_q == ST_DRAIN) ? drain_q + 2'd1 : 2'd0;
            vsync_d <= in_vsync;
        end
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (vs_rise) begin
                    start   = 1'b1;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (!in_vsync)
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_q == 2'(DRAIN_CYC - 1))
                    state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- optional window ----------------
`ifdef ISP_STAT_AWB_WINDOW_EN
    logic [11:0] x_cnt, y_cnt;
    logic        href_d;

    // x is the index of the current pixel within its line; y counts
    // completed lines since frame start.
    always_ff @(posedge pclk) begin
        if (rst) begin
            x_cnt  <= '0;
            y_cnt  <= '0;
            href_d <= 1'b0;
        end else begin
            href_d <= in_href;
            x_cnt  <= in_href ? x_cnt + 12'd1 : 12'd0;
            if (start)
                y_cnt <= '0;
            else if (href_d && !in_href)
                y_cnt <= y_cnt + 12'd1;
        end
    end

    assign win_ok = (x_cnt >= win_x0) && (x_cnt <= win_x1) &&
                    (y_cnt >= win_y0) && (y_cnt <= win_y1);
`else
    assign win_ok = 1'b1;
`endif

    // ---------------- stage 1: qualify ----------------
    assign ext_r = {{(ACC_W-BITS){1'b0}}, in_r};
    assign ext_g = {{(ACC_W-BITS){1'b0}}, in_g};
    assign ext_b = {{(ACC_W-BITS){1'b0}}, in_b};

    assign in_range = (ext_r >= DARK_V) && (ext_r < SAT_V) &&
                      (ext_g >= DARK_V) && (ext_g < SAT_V) &&
                      (ext_b >= DARK_V) && (ext_b < SAT_V);

    assign qual = in_href && in_vsync && (state_q == ST_ACCUM) &&
                  in_range && win_ok;

    always_ff @(posedge pclk) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_r   <= '0;
            s1_g   <= '0;
            s1_b   <= '0;
        end else begin
            s1_vld <= qual;
            s1_r   <= ext_r;
            s1_g   <= ext_g;
            s1_b   <= ext_b;
        end
    end

    // ---------------- stage 2: accumulate ----------------
    sat_acc32 u_acc_cnt (.pclk(pclk), .rst(rst), .clr(start), .en(s1_vld),
                         .add(ACC_W'(1)), .acc(acc_cnt));
    sat_acc32 u_acc_r   (.pclk(pclk), .rst(rst), .clr(start), .en(s1_vld),
                         .add(s1_r), .acc(acc_r));
    sat_acc32 u_acc_g   (.pclk(pclk), .rst(rst), .clr(start), .en(s1_vld),
                         .add(s1_g), .acc(acc_g));
    sat_acc32 u_acc_b   (.pclk(pclk), .rst(rst), .clr(start), .en(s1_vld),
                         .add(s1_b), .acc(acc_b));

    // ---------------- result publish ----------------
    always_ff @(posedge pclk) begin
        if (rst) begin
            stat_done <= 1'b0;
            pix_cnt   <= '0;
            sum_r     <= '0;
            sum_g     <= '0;
            sum_b     <= '0;
        end else begin
            stat_done <= (state_q == ST_DONE);
            if (state_q == ST_DONE) begin
                pix_cnt <= acc_cnt;
                sum_r   <= acc_r;
                sum_g   <= acc_g;
                sum_b   <= acc_b;
            end
        end
    end

endmodule
